opl3_clk_en_gen: RTL and testbench

- Parametrised, fractional-N clock-enable generator; successor to the fixed integer CLK_DIV_COUNT sample-enable scheme.
- Produces a one-cycle sample_clk_en at an average rate of CLK_FREQ*INC/MOD, plus NUM_SUB aligned sub-rate enables (timer1 80 us, timer2 320 us ticks).
- INC/MOD are runtime-reprogrammable with glitch-free switchover at a sample boundary.
- Sits at the top of the OPL3 core and drives the operator pipeline, envelope and timer blocks.

---
 rtl/opl3_clk_en_gen.sv | 86 ++++++++
 tb/tb_opl3_clk_en_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_clk_en_gen.sv
// opl3_clk_en_gen: fractional-N sample clock enable (rate inc/mod) with aligned sub-rate enables
// and glitch-free runtime reconfiguration at sample boundaries.
module opl3_clk_en_gen #(
    parameter int ACC_WIDTH = 24,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 1,
    parameter logic [ACC_WIDTH-1:0] DEFAULT_MOD = 256,
    parameter int NUM_SUB = 2,
    parameter int SUB_DIV_WIDTH = 8,
    parameter logic [NUM_SUB-1:0][SUB_DIV_WIDTH-1:0] SUB_DIV = {8'd16, 8'd4}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 restart,
    input  logic                 cfg_wr,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic [ACC_WIDTH-1:0] cfg_mod,
    output logic                 sample_clk_en,
    output logic [NUM_SUB-1:0]   sub_clk_en,
    output logic                 cfg_pending,
    output logic                 cfg_err
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d, mod_q, mod_d;
    logic [ACC_WIDTH-1:0] sh_inc_q, sh_inc_d, sh_mod_q, sh_mod_d;
    logic [NUM_SUB-1:0][SUB_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_SUB-1:0] sub_q, sub_d;
    logic sample_q, sample_d, pend_q, pend_d, err_q, err_d;
    logic [ACC_WIDTH:0] sum, wrap;
    logic wr_ok, run, pulse, use_new, use_shadow;

    always_comb begin
        wr_ok = cfg_wr && cfg_inc != '0 && cfg_inc <= cfg_mod;
        run = en && !restart;
        sum = {1'b0, acc_q} + {1'b0, inc_q};
        wrap = sum - {1'b0, mod_q};
        pulse = run && sum >= {1'b0, mod_q};
        sample_d = pulse;
        acc_d = restart ? '0 : !en ? acc_q : pulse ? wrap[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
        sub_d = '0;
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_SUB; i++) begin
            sub_d[i] = pulse && cnt_q[i] == SUB_DIV[i] - SUB_DIV_WIDTH'(1);
            cnt_d[i] = (restart || sub_d[i]) ? '0 : pulse ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
        // While idle a fresh write wins outright; at a boundary only the older shadow applies
        use_new = !run && wr_ok;
        use_shadow = (!run || pulse) && pend_q && !use_new;
        inc_d = use_new ? cfg_inc : use_shadow ? sh_inc_q : inc_q;
        mod_d = use_new ? cfg_mod : use_shadow ? sh_mod_q : mod_q;
        sh_inc_d = wr_ok ? cfg_inc : sh_inc_q;
        sh_mod_d = wr_ok ? cfg_mod : sh_mod_q;
        pend_d = run && (wr_ok || (pend_q && !pulse));
        err_d = cfg_wr ? !wr_ok : err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            inc_q <= DEFAULT_INC;
            mod_q <= DEFAULT_MOD;
            sh_inc_q <= DEFAULT_INC;
            sh_mod_q <= DEFAULT_MOD;
            cnt_q <= '0;
            sub_q <= '0;
            sample_q <= 1'b0;
            pend_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            mod_q <= mod_d;
            sh_inc_q <= sh_inc_d;
            sh_mod_q <= sh_mod_d;
            cnt_q <= cnt_d;
            sub_q <= sub_d;
            sample_q <= sample_d;
            pend_q <= pend_d;
            err_q <= err_d;
        end
    end

    assign sample_clk_en = sample_q;
    assign sub_clk_en = sub_q;
    assign cfg_pending = pend_q;
    assign cfg_err = err_q;
endmodule

// File: tb/tb_opl3_clk_en_gen.sv
// tb_opl3_clk_en_gen: checks opl3_clk_en_gen against a pulse-count reference model every cycle,
// plus literal timing expectations for the directed scenarios.
module tb_opl3_clk_en_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0, restart = 1'b0, cfg_wr = 1'b0;
    logic [23:0] cfg_inc = '0, cfg_mod = '0;
    logic sample_clk_en, cfg_pending, cfg_err;
    logic [1:0] sub_clk_en;

    int errors = 0;
    int checks = 0;

    opl3_clk_en_gen dut (
        .clk(clk), .reset_n(reset_n), .en(en), .restart(restart), .cfg_wr(cfg_wr),
        .cfg_inc(cfg_inc), .cfg_mod(cfg_mod), .sample_clk_en(sample_clk_en),
        .sub_clk_en(sub_clk_en), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: sub channel i fires when the pulse count since restart is a multiple of its divisor
    int sub_div [2] = '{4, 16};
    longint m_acc = 0, m_inc = 1, m_mod = 256, m_sinc = 1, m_smod = 256, s;
    int m_pcnt = 0;
    bit m_pend = 0, m_err = 0, m_samp = 0, ok;
    bit [1:0] m_sub = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc = 0; m_inc = 1; m_mod = 256; m_pend = 0; m_err = 0;
            m_samp = 0; m_sub = '0; m_pcnt = 0;
        end else begin
            ok = cfg_wr && cfg_inc != 0 && cfg_inc <= cfg_mod;
            if (cfg_wr) m_err = !ok;
            if (restart || !en) begin
                m_samp = 0;
                m_sub = '0;
                if (restart) begin
                    m_acc = 0;
                    m_pcnt = 0;
                end
                if (ok) begin
                    m_inc = cfg_inc; m_mod = cfg_mod;
                end else if (m_pend) begin
                    m_inc = m_sinc; m_mod = m_smod;
                end
                m_pend = 0;
            end else begin
                s = m_acc + m_inc;
                m_samp = s >= m_mod;
                m_acc = m_samp ? s - m_mod : s;
                m_sub = '0;
                if (m_samp) begin
                    m_pcnt++;
                    for (int i = 0; i < 2; i++) m_sub[i] = (m_pcnt % sub_div[i]) == 0;
                    if (m_pend) begin
                        m_inc = m_sinc; m_mod = m_smod; m_pend = 0;
                    end
                end
                if (ok) begin
                    m_sinc = cfg_inc; m_smod = cfg_mod; m_pend = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({sample_clk_en, sub_clk_en, cfg_pending, cfg_err} !== {m_samp, m_sub, m_pend, m_err}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got samp=%b sub=%b pend=%b err=%b, expected samp=%b sub=%b pend=%b err=%b",
                     $time, sample_clk_en, sub_clk_en, cfg_pending, cfg_err, m_samp, m_sub, m_pend, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_pulse(input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_clk_en && n < lim);
        if (!sample_clk_en) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout: no sample_clk_en within %0d edges", lim);
        end
    endtask

    task automatic write_cfg(input int inc, input int md);
        cfg_wr = 1'b1;
        cfg_inc = 24'(inc);
        cfg_mod = 24'(md);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic idle_defaults();
        en = 1'b0;
        write_cfg(1, 256);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        en = 1'b1;
    endtask

    task automatic default_run(input int npulses, input string tag);
        int n;
        for (int k = 1; k <= npulses; k++) begin
            wait_pulse(300, n);
            chk({tag, "_gap"}, n, 256);
            chk({tag, "_sub0"}, sub_clk_en[0], (k % 4) == 0);
            chk({tag, "_sub1"}, sub_clk_en[1], (k % 16) == 0);
        end
    endtask

    initial begin
        int n;
        int gaps [6] = '{3, 3, 2, 3, 3, 2};
        int m;
        #22;
        chk("reset_outputs", {sample_clk_en, sub_clk_en, cfg_pending, cfg_err}, 0);
        en = 1'b1;
        reset_n = 1'b1;
        default_run(16, "defaults");

        en = 1'b0;
        write_cfg(7, 1792);
        chk("idle_apply_pending", cfg_pending, 0);
        en = 1'b1;
        wait_pulse(400, n);
        chk("inc7_mod1792_gap", n, 256);
        en = 1'b0;
        write_cfg(3, 8);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_pulse(20, n);
            chk("inc3_mod8_gap", n, gaps[k]);
        end

        cfg_inc = 0;
        write_cfg(0, 8);
        chk("inc0_err", cfg_err, 1);
        chk("inc0_pending", cfg_pending, 0);
        write_cfg(9, 8);
        chk("inc_gt_mod_err", cfg_err, 1);
        wait_pulse(20, n);
        chk("rate_kept_after_err", n <= 3 && n >= 1, 1);
        en = 1'b0;
        write_cfg(1, 256);
        chk("valid_clears_err", cfg_err, 0);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        en = 1'b1;
        repeat (100) tick();
        write_cfg(1, 128);
        chk("midrun_pending", cfg_pending, 1);
        wait_pulse(300, n);
        chk("midrun_old_rate", n, 155);
        chk("midrun_pending_clear", cfg_pending, 0);
        wait_pulse(300, n);
        chk("midrun_new_rate", n, 128);

        idle_defaults();
        repeat (255) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_no_pulse", {sample_clk_en, sub_clk_en}, 0);
        default_run(4, "after_restart");

        repeat (3000) begin
            en = $urandom_range(0, 9) != 0;
            restart = $urandom_range(0, 99) == 0;
            cfg_wr = $urandom_range(0, 29) == 0;
            m = $urandom_range(1, 40);
            cfg_mod = 24'(m);
            cfg_inc = 24'($urandom_range(0, m + 1));
            tick();
        end
        cfg_wr = 1'b0;
        restart = 1'b0;

        idle_defaults();
        write_cfg(0, 8);
        wait_pulse(300, n);
        #2;
        chk("pre_reset_active", sample_clk_en && cfg_err, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {sample_clk_en, sub_clk_en, cfg_pending, cfg_err}, 0);
        repeat (2) tick();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        default_run(4, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
